// File: rtl/bmp_stream_encoder.sv
`default_nettype none
// ============================================================================
// Module      : bmp_stream_encoder
// Description : Turns a stream of 24-bit RGB pixels into a complete 24-bpp
//               BMP file byte stream. The stream is a 54-byte header, then
//               the pixel data, with every row padded to a multiple of 4 bytes.
// Revision    : 1.0  initial release
// ============================================================================
module bmp_stream_encoder #(
  parameter int DIM_W = 11,
  parameter int PPM   = 2835
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             start,
  input  logic [DIM_W-1:0] width,
  input  logic [DIM_W-1:0] height,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic [7:0]       pix_r,
  input  logic [7:0]       pix_g,
  input  logic [7:0]       pix_b,
  output logic             byte_valid,
  input  logic             byte_ready,
  output logic [7:0]       byte_data,
  output logic             byte_last,
  output logic             busy,
  output logic             frame_done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_PIX  = 3'd2,
    S_PAD  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [31:0]      PPM_VAL = 32'(PPM);
  localparam logic [DIM_W-1:0] DIM_ONE = {{(DIM_W-1){1'b0}}, 1'b1};
  localparam logic [5:0]       HDR_LAST = 6'd53;

  state_t           state_q, state_d;
  logic [DIM_W-1:0] w_q, w_d, h_q, h_d;
  logic [1:0]       pad_q, pad_d;
  logic [31:0]      img_size_q, img_size_d;
  logic [31:0]      file_size_q, file_size_d;
  logic [5:0]       hdr_idx_q, hdr_idx_d;
  logic [DIM_W-1:0] col_q, col_d, row_q, row_d;
  logic [23:0]      pix_q, pix_d;
  logic             pix_full_q, pix_full_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       pad_cnt_q, pad_cnt_d;

  // Frame geometry derived from the inputs, latched only on an accepted start.
  logic [31:0] width_ext, height_ext, stride_new, img_size_new;
  logic        start_ok;
  assign width_ext    = {{(32-DIM_W){1'b0}}, width};
  assign height_ext   = {{(32-DIM_W){1'b0}}, height};
  assign stride_new   = (width_ext * 32'd3) + {30'd0, width[1:0]};
  assign img_size_new = stride_new * height_ext;
  assign start_ok     = start && (width != '0) && (height != '0);

  logic col_last, row_last, pad_last;
  assign col_last = (col_q == (w_q - DIM_ONE));
  assign row_last = (row_q == (h_q - DIM_ONE));
  assign pad_last = (pad_cnt_q == (pad_q - 2'd1));

  // Header byte lookup. From index 2 onward every field lines up on a 4-byte
  // boundary (the two 16-bit fields planes/bpp are packed as one word), so the
  // field is chosen by (idx-2)/4 and the byte within it by (idx-2)%4.
  logic [5:0]  hdr_off;
  logic [31:0] hdr_field;
  logic [7:0]  hdr_byte;
  always_comb begin
    hdr_off   = hdr_idx_q - 6'd2;
    hdr_field = 32'd0;
    hdr_byte  = 8'd0;
    case (hdr_off[5:2])
      4'd0:        hdr_field = file_size_q;
      4'd2:        hdr_field = 32'd54;
      4'd3:        hdr_field = 32'd40;
      4'd4:        hdr_field = {{(32-DIM_W){1'b0}}, w_q};
      4'd5:        hdr_field = {{(32-DIM_W){1'b0}}, h_q};
      4'd6:        hdr_field = 32'h0018_0001;
      4'd8:        hdr_field = img_size_q;
      4'd9, 4'd10: hdr_field = PPM_VAL;
      default:     hdr_field = 32'd0;
    endcase
    case (hdr_off[1:0])
      2'd0:    hdr_byte = hdr_field[7:0];
      2'd1:    hdr_byte = hdr_field[15:8];
      2'd2:    hdr_byte = hdr_field[23:16];
      default: hdr_byte = hdr_field[31:24];
    endcase
    if (hdr_idx_q == 6'd0) begin
      hdr_byte = 8'h42;
    end else if (hdr_idx_q == 6'd1) begin
      hdr_byte = 8'h4D;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q     <= S_IDLE;
      w_q         <= '0;
      h_q         <= '0;
      pad_q       <= 2'd0;
      img_size_q  <= 32'd0;
      file_size_q <= 32'd0;
      hdr_idx_q   <= 6'd0;
      col_q       <= '0;
      row_q       <= '0;
      pix_q       <= 24'd0;
      pix_full_q  <= 1'b0;
      sel_q       <= 2'd0;
      pad_cnt_q   <= 2'd0;
    end else begin
      state_q     <= state_d;
      w_q         <= w_d;
      h_q         <= h_d;
      pad_q       <= pad_d;
      img_size_q  <= img_size_d;
      file_size_q <= file_size_d;
      hdr_idx_q   <= hdr_idx_d;
      col_q       <= col_d;
      row_q       <= row_d;
      pix_q       <= pix_d;
      pix_full_q  <= pix_full_d;
      sel_q       <= sel_d;
      pad_cnt_q   <= pad_cnt_d;
    end
  end

  // Next-state logic: walk header, pixel bytes (B,G,R), row padding, done.
  always_comb begin
    state_d     = state_q;
    w_d         = w_q;
    h_d         = h_q;
    pad_d       = pad_q;
    img_size_d  = img_size_q;
    file_size_d = file_size_q;
    hdr_idx_d   = hdr_idx_q;
    col_d       = col_q;
    row_d       = row_q;
    pix_d       = pix_q;
    pix_full_d  = pix_full_q;
    sel_d       = sel_q;
    pad_cnt_d   = pad_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          w_d         = width;
          h_d         = height;
          pad_d       = width[1:0];
          img_size_d  = img_size_new;
          file_size_d = img_size_new + 32'd54;
          hdr_idx_d   = 6'd0;
          state_d     = S_HDR;
        end
      end
      S_HDR: begin
        if (byte_ready) begin
          if (hdr_idx_q == HDR_LAST) begin
            hdr_idx_d  = 6'd0;
            col_d      = '0;
            row_d      = '0;
            sel_d      = 2'd0;
            pix_full_d = 1'b0;
            state_d    = S_PIX;
          end else begin
            hdr_idx_d = hdr_idx_q + 6'd1;
          end
        end
      end
      S_PIX: begin
        if (!pix_full_q) begin
          if (pix_valid) begin
            pix_d      = {pix_r, pix_g, pix_b};
            pix_full_d = 1'b1;
            sel_d      = 2'd0;
          end
        end else if (byte_ready) begin
          if (sel_q == 2'd2) begin
            pix_full_d = 1'b0;
            sel_d      = 2'd0;
            if (col_last) begin
              col_d = '0;
              if (pad_q != 2'd0) begin
                pad_cnt_d = 2'd0;
                state_d   = S_PAD;
              end else if (row_last) begin
                state_d = S_DONE;
              end else begin
                row_d = row_q + DIM_ONE;
              end
            end else begin
              col_d = col_q + DIM_ONE;
            end
          end else begin
            sel_d = sel_q + 2'd1;
          end
        end
      end
      S_PAD: begin
        if (byte_ready) begin
          if (pad_last) begin
            pad_cnt_d = 2'd0;
            if (row_last) begin
              state_d = S_DONE;
            end else begin
              row_d   = row_q + DIM_ONE;
              state_d = S_PIX;
            end
          end else begin
            pad_cnt_d = pad_cnt_q + 2'd1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode; everything depends only on registered state, so data and
  // last stay stable for as long as the sink stalls.
  always_comb begin
    pix_ready  = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'd0;
    byte_last  = 1'b0;
    busy       = (state_q != S_IDLE);
    frame_done = (state_q == S_DONE);
    case (state_q)
      S_HDR: begin
        byte_valid = 1'b1;
        byte_data  = hdr_byte;
      end
      S_PIX: begin
        pix_ready  = !pix_full_q;
        byte_valid = pix_full_q;
        if (pix_full_q) begin
          case (sel_q)
            2'd0:    byte_data = pix_q[7:0];
            2'd1:    byte_data = pix_q[15:8];
            default: byte_data = pix_q[23:16];
          endcase
          byte_last = (sel_q == 2'd2) && col_last && row_last && (pad_q == 2'd0);
        end
      end
      S_PAD: begin
        byte_valid = 1'b1;
        byte_last  = pad_last && row_last;
      end
      default: begin
        byte_valid = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_bmp_stream_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_bmp_stream_encoder
// Description : Directed self-checking bench for bmp_stream_encoder.
// Revision    : 1.0  initial release
// ============================================================================
module tb_bmp_stream_encoder;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        start;
  logic [10:0] width, height;
  logic        pix_valid, pix_ready;
  logic [7:0]  pix_r, pix_g, pix_b;
  logic        byte_valid, byte_ready, byte_last, busy, frame_done;
  logic [7:0]  byte_data;

  bmp_stream_encoder #(.DIM_W(11), .PPM(2835)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .width(width), .height(height),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_data(byte_data),
    .byte_last(byte_last), .busy(busy), .frame_done(frame_done)
  );

  always #5 HCLK = ~HCLK;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got[$];
  int         pix_cnt, rdy_cnt, last_idx;

  function automatic logic [7:0] fr(input int p); return 8'h80 | 8'(p); endfunction
  function automatic logic [7:0] fg(input int p); return 8'h40 | 8'(p); endfunction
  function automatic logic [7:0] fb(input int p); return 8'h20 | 8'(p); endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put32(input int v);
    logic [31:0] x;
    x = v;
    exp_q.push_back(x[7:0]);   exp_q.push_back(x[15:8]);
    exp_q.push_back(x[23:16]); exp_q.push_back(x[31:24]);
  endtask

  task automatic put16(input int v);
    logic [15:0] x;
    x = 16'(v);
    exp_q.push_back(x[7:0]); exp_q.push_back(x[15:8]);
  endtask

  // Reference BMP file for pixel p = row*w + col carrying (fr,fg,fb)(p).
  task automatic build_exp(input int w, input int h);
    int pad, img, p;
    pad = w % 4;
    img = (3 * w + pad) * h;
    exp_q.delete();
    exp_q.push_back(8'h42); exp_q.push_back(8'h4D);
    put32(img + 54); put32(0); put32(54);
    put32(40); put32(w); put32(h);
    put16(1); put16(24);
    put32(0); put32(img);
    put32(2835); put32(2835);
    put32(0); put32(0);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        p = r * w + c;
        exp_q.push_back(fb(p)); exp_q.push_back(fg(p)); exp_q.push_back(fr(p));
      end
      for (int k = 0; k < pad; k++) exp_q.push_back(8'h00);
    end
  endtask

  task automatic do_start(input logic [10:0] w, input logic [10:0] h);
    @(negedge HCLK);
    width = w; height = h; start = 1'b1;
    @(negedge HCLK);
    start = 1'b0;
  endtask

  // Runs one frame, collecting bytes; rnd randomises both handshakes,
  // inj pulses start with other dimensions while the frame is busy.
  task automatic run_frame(input string tag, input int w, input int h, input bit rnd, input bit inj);
    int         done_cyc, last_cyc, mism;
    bit         stall_prev;
    logic [7:0] prev_data;
    logic       prev_last;
    build_exp(w, h);
    got.delete();
    pix_cnt = 0; rdy_cnt = 0; last_idx = -1;
    done_cyc = -1; last_cyc = -2; stall_prev = 0; prev_data = 0; prev_last = 0;
    do_start(11'(w), 11'(h));
    check({tag, " first byte valid"}, 32'(byte_valid), 32'd1);
    check({tag, " first byte 0x42"}, 32'(byte_data), 32'h42);
    for (int cyc = 0; cyc < 4000 && done_cyc < 0; cyc++) begin
      if (stall_prev) begin
        check({tag, " stall valid held"}, 32'(byte_valid), 32'd1);
        check({tag, " stall data held"}, 32'(byte_data), 32'(prev_data));
        check({tag, " stall last held"}, 32'(byte_last), 32'(prev_last));
      end
      if (frame_done) done_cyc = cyc;
      if (pix_ready) rdy_cnt++;
      pix_valid  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      byte_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      pix_r = fr(pix_cnt); pix_g = fg(pix_cnt); pix_b = fb(pix_cnt);
      if (inj && cyc == 5) begin
        start = 1'b1; width = 11'd5; height = 11'd7;
      end else begin
        start = 1'b0;
      end
      if (byte_valid && byte_ready) begin
        got.push_back(byte_data);
        if (byte_last) last_idx = got.size() - 1;
        last_cyc = cyc;
      end
      if (pix_valid && pix_ready) pix_cnt++;
      stall_prev = byte_valid && !byte_ready;
      prev_data  = byte_data;
      prev_last  = byte_last;
      @(negedge HCLK);
    end
    start = 1'b0;
    check({tag, " completed in budget"}, 32'(done_cyc >= 0), 32'd1);
    check({tag, " frame_done one cycle after last"}, 32'(done_cyc), 32'(last_cyc + 1));
    check({tag, " frame_done single pulse"}, 32'(frame_done), 32'd0);
    check({tag, " idle after frame"}, 32'(busy), 32'd0);
    check({tag, " byte count"}, 32'(got.size()), 32'(exp_q.size()));
    mism = 0;
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      if (got[i] !== exp_q[i]) mism++;
    check({tag, " byte mismatches"}, 32'(mism), 32'd0);
    check({tag, " byte_last index"}, 32'(last_idx), 32'(exp_q.size() - 1));
    check({tag, " pixels taken"}, 32'(pix_cnt), 32'(w * h));
  endtask

  task automatic check_bytes(input string tag, input int base, input logic [31:0] word);
    for (int i = 0; i < 4; i++)
      check(tag, (base + i < got.size()) ? 32'(got[base + i]) : 32'hDEAD, 32'(word[8*i +: 8]));
  endtask

  initial begin
    HRESETn = 1'b0; start = 1'b0; width = '0; height = '0;
    pix_valid = 1'b0; pix_r = '0; pix_g = '0; pix_b = '0; byte_ready = 1'b0;
    repeat (3) @(negedge HCLK);
    check("reset byte_valid", 32'(byte_valid), 32'd0);
    check("reset pix_ready", 32'(pix_ready), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset frame_done", 32'(frame_done), 32'd0);
    check("reset byte_data", 32'(byte_data), 32'd0);
    HRESETn = 1'b1;
    @(negedge HCLK);

    // W=2,H=2: pad 2, file 70 (0x46), image 16 (0x10)
    run_frame("w2h2", 2, 2, 1'b0, 1'b0);
    check_bytes("w2h2 file_size", 2, 32'h0000_0046);
    check_bytes("w2h2 img_size", 34, 32'h0000_0010);
    check_bytes("w2h2 row0 a", 54, 32'h21_80_40_20);
    check_bytes("w2h2 row0 b", 58, 32'h00_00_81_41);
    check_bytes("w2h2 row1 a", 62, 32'h23_82_42_22);
    check_bytes("w2h2 row1 b", 66, 32'h00_00_83_43);

    // W=4,H=1: no padding, file 66 (0x42), last byte is R of pixel 3
    run_frame("w4h1", 4, 1, 1'b0, 1'b0);
    check_bytes("w4h1 file_size", 2, 32'h0000_0042);
    check("w4h1 last byte", (got.size() == 66) ? 32'(got[65]) : 32'hDEAD, 32'h83);

    // W=3,H=2 with random stalls on both sides
    byte_ready = 1'b0;
    run_frame("w3h2 rnd", 3, 2, 1'b1, 1'b0);
    check_bytes("w3h2 file_size", 2, 32'd78);

    // Rejected starts: zero width, zero height
    do_start(11'd0, 11'd3);
    check("w0 start busy", 32'(busy), 32'd0);
    check("w0 start byte_valid", 32'(byte_valid), 32'd0);
    do_start(11'd3, 11'd0);
    @(negedge HCLK);
    check("h0 start busy", 32'(busy), 32'd0);
    check("h0 start byte_valid", 32'(byte_valid), 32'd0);

    // start pulsed mid-frame must not disturb the running W=2,H=2 frame
    run_frame("busy start", 2, 2, 1'b0, 1'b1);

    // Reset while header byte 20 is on the bus
    do_start(11'd2, 11'd2);
    byte_ready = 1'b1;
    repeat (20) @(negedge HCLK);
    check("hdr byte 20", 32'(byte_data), 32'h00);
    check("hdr busy before reset", 32'(busy), 32'd1);
    HRESETn = 1'b0;
    @(negedge HCLK);
    HRESETn = 1'b1;
    check("midreset byte_valid", 32'(byte_valid), 32'd0);
    check("midreset byte_data", 32'(byte_data), 32'd0);
    check("midreset byte_last", 32'(byte_last), 32'd0);
    check("midreset pix_ready", 32'(pix_ready), 32'd0);
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset frame_done", 32'(frame_done), 32'd0);
    run_frame("after reset", 2, 2, 1'b0, 1'b0);

    // W=1,H=3: pad 1, 66 bytes, one accepted pixel per row
    run_frame("w1h3", 1, 3, 1'b0, 1'b0);
    check("w1h3 pix_ready cycles", 32'(rdy_cnt), 32'd3);
    check_bytes("w1h3 row0", 54, 32'h00_80_40_20);
    check_bytes("w1h3 row2", 62, 32'h00_82_42_22);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bmp_stream_encoder.md
Name: bmp_stream_encoder

Overview:
Synthesizable counterpart to the behavioural BMP reader. Accepts a pixel stream of 24-bit RGB pixels and emits a complete 24-bpp BMP file as a byte stream. The output is a 54-byte header followed by pixel data with each row padded to 4 bytes. It sits between the image-processing datapath and a byte sink (UART/DMA/file-dump model) in the image pipeline.

Parameters:
DIM_W, 11, width of the width/height inputs and the internal row/column counters
PPM, 2835, value written to both the X and Y pixels-per-metre header fields

Ports:
HCLK  in  1  clock, all logic rising-edge
HRESETn  in  1  synchronous active-low reset
start  in  1  one-cycle request to begin a frame; only honoured in IDLE
width  in  DIM_W  image width in pixels, sampled on accepted start
height  in  DIM_W  image height in rows, sampled on accepted start
pix_valid  in  1  pixel input valid
pix_ready  out  1  encoder can take a pixel
pix_r  in  8  red
pix_g  in  8  green
pix_b  in  8  blue
byte_valid  out  1  byte_data valid
byte_ready  in  1  sink accepts byte
byte_data  out  8  output byte
byte_last  out  1  marks the final byte of the file
busy  out  1  high in any state other than IDLE
frame_done  out  1  one-cycle pulse after the last byte is accepted

Behaviour:
- Clock and reset: one clock, HCLK. HRESETn is synchronous and active-low.
- Reset values: all outputs are 0, state is IDLE, and all counters are 0. A reset mid-frame abandons the frame immediately; no partial flush.
- start handling:
  - start is accepted in IDLE only when width!=0 and height!=0.
  - Otherwise it is ignored, and start while busy is always ignored.
- Latched values on accepted start: W, H, pad=W[1:0], stride=3*W+pad, img_size=stride*H (32-bit), file_size=img_size+54 (32-bit).
- Latency: byte_valid=1 with byte_data=0x42 in the cycle after start is accepted.
- Output handshake: a byte transfers when byte_valid&byte_ready. byte_data and byte_last are held stable while byte_valid&!byte_ready. byte_valid never drops without a transfer.
- States:
  - IDLE -> HDR on accepted start.
  - HDR: emit 54 bytes in order, all multi-byte fields little-endian:
    - 0x42, 0x4D
    - file_size(4), 0(4), 54(4)
    - 40(4), W(4), H(4)
    - 1(2), 24(2)
    - 0(4), img_size(4)
    - PPM(4), PPM(4)
    - 0(4), 0(4)
    - Header byte counter runs 0..53. After index 53 transfers -> PIX.
  - PIX:
    - pix_ready=1 only in PIX with the holding register empty.
    - On pix_valid&pix_ready, latch {r,g,b}. Emit B, then G, then R. pix_ready stays 0 until R transfers.
    - Pixels are taken in BMP storage order (bottom row first, left to right); the upstream supplies them in that order.
    - After R of column W-1: go to PAD if pad!=0, else advance the row, or go to DONE if the row was H-1.
    - pix_valid outside PIX is ignored.
  - PAD: emit pad bytes of 0x00 (1..3), then advance the row, or -> DONE after row H-1.
  - DONE: frame_done=1 for exactly one cycle, then -> IDLE.
- byte_last: asserted with the final byte of the file, i.e. the last pad byte if pad!=0, else the last R byte.
- Byte count: total bytes transferred always equals file_size.
- Throughput: with byte_ready held high, one byte per cycle. A one-cycle bubble between pixels is allowed (pixel latch cycle).

Test Plan:
1. W=2, H=2, continuous valid/ready:
   - 70 bytes total.
   - Header bytes 2..5 = 46 00 00 00; bytes 34..37 = 10 00 00 00.
   - Each row = B0 G0 R0 B1 G1 R1 00 00.
   - byte_last on byte 69; frame_done 1 cycle later.
2. W=4, H=1:
   - pad=0, 66 bytes, file_size 0x42.
   - No zero bytes after pixel data; byte_last on the R of pixel 3.
3. W=3, H=2:
   - byte_ready random 50%, pix_valid random.
   - Output byte sequence identical to the unstalled run.
   - byte_data stable during every stall; no pixel lost or duplicated.
4. start with W=0, or start asserted while busy:
   - No state change, byte_valid stays 0 or the current frame is unaffected.
5. HRESETn low for one cycle at header byte 20:
   - Next cycle all outputs are 0 and busy=0.
   - A new start then produces a fresh 0x42 header.
6. W=1, H=3, byte_ready held high:
   - 54+3*4=66 bytes, each row B G R 00.
   - pix_ready high exactly 3 times across the frame.
